// File: rtl/qblock_pkg.sv
// rtl/qblock_pkg.sv - shared types and widths for the question-block sprite reader
package qblock_pkg;

    typedef enum logic [2:0] {
        S_F0,
        S_F1_UP,
        S_F2,
        S_F1_DN,
        S_USED
    } anim_state_t;

    localparam int SPRITE_ADDR_W = 9;
    localparam int COLOR_W       = 12;

endpackage

// File: rtl/qblock_sprite_reader_if.sv
// rtl/qblock_sprite_reader_if.sv - draw-coordinate / ROM / pixel bus of the sprite reader
//   master: the reader (drives read_address, pixel_color, pixel_on)
//   slave : the video side (drives coordinates, block position, ROM colours)
interface qblock_sprite_reader_if;
    import qblock_pkg::*;

    logic                     pix_valid;
    logic [9:0]               DrawX;
    logic [9:0]               DrawY;
    logic [9:0]               BlockX;
    logic [9:0]               BlockY;
    logic [SPRITE_ADDR_W-1:0] read_address;
    logic [COLOR_W-1:0]       rom_color_0;
    logic [COLOR_W-1:0]       rom_color_1;
    logic [COLOR_W-1:0]       rom_color_2;
    logic [COLOR_W-1:0]       pixel_color;
    logic                     pixel_on;

    modport master (
        input  pix_valid, DrawX, DrawY, BlockX, BlockY,
        input  rom_color_0, rom_color_1, rom_color_2,
        output read_address, pixel_color, pixel_on
    );

    modport slave (
        output pix_valid, DrawX, DrawY, BlockX, BlockY,
        output rom_color_0, rom_color_1, rom_color_2,
        input  read_address, pixel_color, pixel_on
    );

endinterface

// File: rtl/qblock_anim_fsm.sv
// rtl/qblock_anim_fsm.sv - blink animation FSM, advances on frame_tick
//   Clk, Reset (sync active-high), frame_tick in; frame_sel out (registered).
//   With QBLOCK_USED_EN: block_used in, used_q out (sticky "used" state).
module qblock_anim_fsm
    import qblock_pkg::*;
#(
    parameter int F0_TICKS = 24,
    parameter int FX_TICKS = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
`ifdef QBLOCK_USED_EN
    input  logic       block_used,
    output logic       used_q,
`endif
    output logic [1:0] frame_sel
);

    localparam logic [7:0] F0_LAST = 8'(F0_TICKS - 1);
    localparam logic [7:0] FX_LAST = 8'(FX_TICKS - 1);

    anim_state_t state, state_nxt;
    logic [7:0]  hold_cnt, hold_nxt, hold_last;
    logic [1:0]  frame_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_F0;
            hold_cnt  <= '0;
            frame_sel <= '0;
`ifdef QBLOCK_USED_EN
            used_q    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            frame_sel <= frame_nxt;
`ifdef QBLOCK_USED_EN
            used_q    <= (state_nxt == S_USED);
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        hold_last = (state == S_F0) ? F0_LAST : FX_LAST;
        if (frame_tick) begin
`ifdef QBLOCK_USED_EN
            if (block_used || state == S_USED) begin
                state_nxt = S_USED;
                hold_nxt  = '0;
            end else begin
`else
            begin
`endif
                if (hold_cnt == hold_last) begin
                    hold_nxt = '0;
                    case (state)
                        S_F0:    state_nxt = S_F1_UP;
                        S_F1_UP: state_nxt = S_F2;
                        S_F2:    state_nxt = S_F1_DN;
                        default: state_nxt = S_F0;
                    endcase
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
        end
    end

    // Decoded from the next state so the registered frame_sel moves one cycle after the tick.
    always_comb begin
        case (state_nxt)
            S_F1_UP, S_F1_DN: frame_nxt = 2'd1;
            S_F2:             frame_nxt = 2'd2;
            default:          frame_nxt = 2'd0;
        endcase
    end

endmodule

// File: rtl/qblock_sprite_reader.sv
// rtl/qblock_sprite_reader.sv - question-block sprite reader top
//   Clk, Reset (sync active-high), frame_tick in; frame_sel out.
//   bus (master): hit test + ROM address (combinational), one-stage pixel pipeline.
//   Optional macro QBLOCK_USED_EN adds block_used and the sticky used-block look.
module qblock_sprite_reader
    import qblock_pkg::*;
#(
    parameter int                  SPR_W      = 20,
    parameter int                  SPR_H      = 20,
    parameter int                  F0_TICKS   = 24,
    parameter int                  FX_TICKS   = 8,
`ifdef QBLOCK_USED_EN
    parameter logic [COLOR_W-1:0]  USED_COLOR = 12'h810,
`endif
    parameter logic [COLOR_W-1:0]  KEY_COLOR  = 12'h59F
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
`ifdef QBLOCK_USED_EN
    input  logic                    block_used,
`endif
    output logic [1:0]              frame_sel,
    qblock_sprite_reader_if.master  bus
);

    logic [10:0]        dx, dy, bx, by;
    logic               hit;
    logic [9:0]         xoff, yoff, addr_full;
    logic [COLOR_W-1:0] rom_sel, out_color;
    logic               opaque;
    logic               used;
    logic [COLOR_W-1:0] color_q;
    logic               on_q;

    qblock_anim_fsm #(
        .F0_TICKS (F0_TICKS),
        .FX_TICKS (FX_TICKS)
    ) u_fsm (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
`ifdef QBLOCK_USED_EN
        .block_used (block_used),
        .used_q     (used),
`endif
        .frame_sel  (frame_sel)
    );

`ifndef QBLOCK_USED_EN
    assign used = 1'b0;
`endif

    // 11-bit compare so BlockX+SPR_W near the 10-bit limit cannot wrap.
    assign dx  = {1'b0, bus.DrawX};
    assign dy  = {1'b0, bus.DrawY};
    assign bx  = {1'b0, bus.BlockX};
    assign by  = {1'b0, bus.BlockY};
    assign hit = !Reset && bus.pix_valid
               && dx >= bx && dx < bx + 11'(SPR_W)
               && dy >= by && dy < by + 11'(SPR_H);

    assign xoff      = bus.DrawX - bus.BlockX;
    assign yoff      = bus.DrawY - bus.BlockY;
    assign addr_full = yoff * 10'(SPR_W) + xoff;
    assign bus.read_address = hit ? SPRITE_ADDR_W'(addr_full) : '0;

    // frame_sel is the pre-tick value in the tick cycle, so a pixel never mixes frames.
    always_comb begin
        case (frame_sel)
            2'd1:    rom_sel = bus.rom_color_1;
            2'd2:    rom_sel = bus.rom_color_2;
            default: rom_sel = bus.rom_color_0;
        endcase
    end

    assign opaque = (rom_sel != KEY_COLOR);

`ifdef QBLOCK_USED_EN
    assign out_color = (used && opaque) ? USED_COLOR : rom_sel;
`else
    assign out_color = used ? '0 : rom_sel;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_q <= '0;
            on_q    <= 1'b0;
        end else begin
            color_q <= hit ? out_color : '0;
            on_q    <= hit && opaque;
        end
    end

    assign bus.pixel_color = color_q;
    assign bus.pixel_on    = on_q;

endmodule

// File: tb/tb_qblock_sprite_reader.sv
// tb/tb_qblock_sprite_reader.sv - directed self-checking bench for qblock_sprite_reader
module tb_qblock_sprite_reader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [1:0] frame_sel;
`ifdef QBLOCK_USED_EN
    logic       block_used;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    qblock_sprite_reader_if bus ();

    qblock_sprite_reader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
`ifdef QBLOCK_USED_EN
        .block_used (block_used),
`endif
        .frame_sel  (frame_sel),
        .bus        (bus.master)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic v, input logic [9:0] x, input logic [9:0] y);
        bus.pix_valid = v;
        bus.DrawX     = x;
        bus.DrawY     = y;
    endtask

    initial begin
        Reset           = 1'b1;
        frame_tick      = 1'b0;
`ifdef QBLOCK_USED_EN
        block_used      = 1'b0;
`endif
        bus.pix_valid   = 1'b0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        bus.BlockX      = 10'd100;
        bus.BlockY      = 10'd50;
        bus.rom_color_0 = 12'hDEF;
        bus.rom_color_1 = 12'h111;
        bus.rom_color_2 = 12'h222;

        // reset state
        step();
        step();
        check("rst_frame_sel", 32'(frame_sel), 32'd0);
        check("rst_pixel_on", 32'(bus.pixel_on), 32'd0);
        check("rst_pixel_color", 32'(bus.pixel_color), 32'd0);
        check("rst_read_address", 32'(bus.read_address), 32'd0);
        Reset = 1'b0;

        // bottom-right corner of the sprite
        set_pix(1'b1, 10'd119, 10'd69);
        #1;
        check("addr_corner", 32'(bus.read_address), 32'd399);
        step();
        check("color_corner", 32'(bus.pixel_color), 32'hDEF);
        check("on_corner", 32'(bus.pixel_on), 32'd1);

        // one column past the right edge
        set_pix(1'b1, 10'd120, 10'd69);
        #1;
        check("addr_outside_x", 32'(bus.read_address), 32'd0);
        step();
        check("on_outside_x", 32'(bus.pixel_on), 32'd0);
        check("color_outside_x", 32'(bus.pixel_color), 32'd0);

        // top-left corner and an interior point
        set_pix(1'b1, 10'd100, 10'd50);
        #1;
        check("addr_top_left", 32'(bus.read_address), 32'd0);
        step();
        check("on_top_left", 32'(bus.pixel_on), 32'd1);
        set_pix(1'b1, 10'd105, 10'd52);
        #1;
        check("addr_interior", 32'(bus.read_address), 32'd45);
        set_pix(1'b1, 10'd99, 10'd52);
        #1;
        check("addr_left_of", 32'(bus.read_address), 32'd0);
        set_pix(1'b1, 10'd105, 10'd70);
        step();
        check("on_below", 32'(bus.pixel_on), 32'd0);

        // pix_valid low inside the sprite
        set_pix(1'b0, 10'd105, 10'd52);
        #1;
        check("addr_invalid", 32'(bus.read_address), 32'd0);
        step();
        check("on_invalid", 32'(bus.pixel_on), 32'd0);

        // transparent key colour
        bus.rom_color_0 = 12'h59F;
        set_pix(1'b1, 10'd110, 10'd60);
        step();
        check("on_key", 32'(bus.pixel_on), 32'd0);
        check("color_key", 32'(bus.pixel_color), 32'h59F);
        set_pix(1'b0, 10'd0, 10'd0);

        // full blink period
        for (int k = 1; k <= 48; k++) begin
            logic [1:0] exp_f;
            tick();
            exp_f = (k < 24) ? 2'd0 : (k < 32) ? 2'd1 : (k < 40) ? 2'd2 : (k < 48) ? 2'd1 : 2'd0;
            check($sformatf("anim_tick_%0d", k), 32'(frame_sel), 32'(exp_f));
        end

        // tick and valid pixel in the same cycle at the F0 -> F1_UP boundary
        for (int k = 0; k < 23; k++) tick();
        check("pre_boundary_frame", 32'(frame_sel), 32'd0);
        bus.rom_color_0 = 12'hABC;
        bus.rom_color_1 = 12'h123;
        set_pix(1'b1, 10'd100, 10'd50);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("simul_old_frame_color", 32'(bus.pixel_color), 32'hABC);
        check("simul_frame_sel", 32'(frame_sel), 32'd1);
        step();
        check("simul_new_frame_color", 32'(bus.pixel_color), 32'h123);
        check("simul_new_frame_on", 32'(bus.pixel_on), 32'd1);

        // reset mid-stream in S_F2 with hold_cnt=3
        set_pix(1'b0, 10'd0, 10'd0);
        for (int k = 0; k < 11; k++) tick();
        check("mid_f2_frame", 32'(frame_sel), 32'd2);
        set_pix(1'b1, 10'd105, 10'd52);
        Reset = 1'b1;
        #1;
        check("mid_rst_addr", 32'(bus.read_address), 32'd0);
        step();
        check("mid_rst_frame", 32'(frame_sel), 32'd0);
        check("mid_rst_on", 32'(bus.pixel_on), 32'd0);
        Reset = 1'b0;
        set_pix(1'b0, 10'd0, 10'd0);
        for (int k = 0; k < 23; k++) tick();
        check("post_rst_23", 32'(frame_sel), 32'd0);
        tick();
        check("post_rst_24", 32'(frame_sel), 32'd1);

`ifdef QBLOCK_USED_EN
        // used block: sticky, frame 0, opaque pixels recoloured
        for (int k = 0; k < 8; k++) tick();
        check("used_pre_f2", 32'(frame_sel), 32'd2);
        block_used = 1'b1;
        tick();
        block_used = 1'b0;
        check("used_frame", 32'(frame_sel), 32'd0);
        bus.rom_color_0 = 12'hDEF;
        bus.rom_color_2 = 12'h222;
        set_pix(1'b1, 10'd101, 10'd51);
        step();
        check("used_color", 32'(bus.pixel_color), 32'h810);
        check("used_on", 32'(bus.pixel_on), 32'd1);
        bus.rom_color_0 = 12'h59F;
        step();
        check("used_key_on", 32'(bus.pixel_on), 32'd0);
        check("used_key_color", 32'(bus.pixel_color), 32'h59F);
        set_pix(1'b0, 10'd0, 10'd0);
        for (int k = 0; k < 100; k++) tick();
        check("used_sticky", 32'(frame_sel), 32'd0);
        bus.rom_color_0 = 12'hDEF;
        set_pix(1'b1, 10'd101, 10'd51);
        step();
        check("used_sticky_color", 32'(bus.pixel_color), 32'h810);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        check("used_cleared_color", 32'(bus.pixel_color), 32'hDEF);
        set_pix(1'b0, 10'd0, 10'd0);
        for (int k = 0; k < 24; k++) tick();
        check("used_cleared_anim", 32'(frame_sel), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/qblock_sprite_reader.md
Name: qblock_sprite_reader

Overview:
Read-side master for the three question-block blink ROMs (frames 0/1/2, 20x20 sprites, 4-bit palette index in, 12-bit RGB out per ROM).
- Takes the VGA draw coordinate and the block's screen position.
- Generates the shared 9-bit read_address and runs the blink animation FSM.
- Selects the returned colour from the current frame's ROM and emits a registered pixel plus an opaque flag to the colour mapper.

Parameters:
SPR_W, 20, sprite width in pixels
SPR_H, 20, sprite height in pixels
F0_TICKS, 24, frame_tick count spent on frame 0 per blink cycle
FX_TICKS, 8, frame_tick count spent on each frame 1/2 step
KEY_COLOR, 12'h59F, ROM colour treated as transparent
USED_COLOR, 12'h810, opaque-pixel colour after block_used (macro only)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
pix_valid  in  1  DrawX/DrawY valid this cycle
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
BlockX  in  10  sprite top-left x
BlockY  in  10  sprite top-left y
read_address  out  9  address driven to all three ROMs
rom_color_0  in  12  colour from frame-0 ROM
rom_color_1  in  12  colour from frame-1 ROM
rom_color_2  in  12  colour from frame-2 ROM
pixel_color  out  12  registered sprite colour
pixel_on  out  1  registered: pixel is inside the sprite and opaque
frame_sel  out  2  current animation frame (debug/visibility)
block_used  in  1  present only with QBLOCK_USED_EN

Behaviour:
- Reset is synchronous, active-high, and valid at any cycle. Outputs on reset: read_address=0, pixel_color=0, pixel_on=0, frame_sel=0. FSM goes to S_F0 and hold_cnt to 0. The pipeline stage is cleared.
- Hit test is combinational on the inputs:
  - in = pix_valid && DrawX>=BlockX && DrawX<BlockX+SPR_W && DrawY>=BlockY && DrawY<BlockY+SPR_H.
  - Compare in 11 bits so BlockX+SPR_W cannot wrap.
- Address:
  - When in: read_address = (DrawY-BlockY)*SPR_W + (DrawX-BlockX). Maximum value is 399, which fits 9 bits.
  - When not in: read_address = 0.
  - read_address is combinational. The ROMs are combinational.
- Pipeline, one register stage:
  - Cycle N captures in_q, frame_q=frame_sel, and the rom_color_{frame_sel} mux result.
  - Cycle N+1 drives pixel_color = captured colour.
  - Cycle N+1 drives pixel_on = in_q && colour != KEY_COLOR.
  - When in_q=0: pixel_color=0 and pixel_on=0.
  - Fixed latency of 1 cycle from DrawX/DrawY to pixel outputs.
- Animation FSM advances only on frame_tick; hold_cnt counts ticks in the current state.
  - Sequence is S_F0 (frame 0, F0_TICKS) -> S_F1_UP (frame 1, FX_TICKS) -> S_F2 (frame 2, FX_TICKS) -> S_F1_DN (frame 1, FX_TICKS) -> S_F0.
  - Transition occurs on the tick where hold_cnt==limit-1; hold_cnt then resets to 0.
  - Full period = F0_TICKS + 3*FX_TICKS ticks (48 by default).
- frame_sel is registered and changes the cycle after the frame_tick.
- If frame_tick coincides with a valid pixel, that pixel uses the old frame_sel. Frame switches never tear within a pixel.
- pix_valid low → pixel_on=0 next cycle regardless of position.

Optional Feature:
QBLOCK_USED_EN
- Defined:
  - Adds the block_used port and state S_USED.
  - A frame_tick while block_used=1 moves any state to S_USED. S_USED is sticky until Reset.
  - In S_USED: frame_sel=0, and opaque pixels output USED_COLOR instead of the ROM colour. Transparency is still judged on the rom_color_0 value.
- Undefined: the port and state are absent and the FSM is the 4-state loop only.

Decomposition:
- Package qblock_pkg holds:
  - typedef enum logic [2:0] anim_state_t {S_F0, S_F1_UP, S_F2, S_F1_DN, S_USED}
  - localparams SPRITE_ADDR_W=9 and COLOR_W=12
- One natural sub-module, qblock_anim_fsm:
  - Ports: Clk, Reset, frame_tick, block_used → frame_sel, used_q.
  - The top level keeps the hit test, address arithmetic and output pipeline.

Test Plan:
- Reset mid-stream (at FSM in S_F2, hold_cnt=3), then Reset=1 for 1 cycle → next cycle frame_sel=0, pixel_on=0, read_address=0; after 23 ticks still frame 0, and the 24th tick → frame_sel=1.
- BlockX=100, BlockY=50, DrawX=119, DrawY=69, pix_valid=1 → read_address=399; at N+1 pixel_color=rom_color_0 (e.g. 12'hDEF) and pixel_on=1. DrawX=120 → read_address=0 and pixel_on=0 next cycle.
- Transparency: rom colour=12'h59F inside the sprite → pixel_on=0, pixel_color=12'h59F.
- Full animation: 48 frame_ticks → frame_sel sequence is 0 for 24 ticks, then 1, 2, 1 for 8 ticks each, then back to 0.
- Simultaneous events: frame_tick and a valid pixel in the same cycle at the S_F0→S_F1_UP boundary → that pixel shows rom_color_0, and the following pixel shows rom_color_1.
- QBLOCK_USED_EN: block_used=1 with a tick while in S_F2 → frame_sel=0, opaque pixels = 12'h810; the state holds through 100 further ticks until Reset.
